// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and the control word carried down the display pipe.
package vga_pkg;
  // 640x480@60 defaults
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int hMaxCount = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800
  localparam int vMaxCount = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

  // Counter width is sized for the default 800x525 raster.
  localparam int CNT_W  = 10;
  localparam int ADDR_W = 19;

  typedef struct packed {
    logic hs;      // active-low
    logic vs;      // active-low
    logic de;
    logic fs;
    logic border;
  } vga_ctl_t;

  // Blanked, sync inactive: the value every delay stage holds after reset.
  localparam vga_ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, border: 1'b0};
endpackage

// File: rtl/vga_timing.sv
// Raster counters and stage-0 decode of visible/sync/border/frame-start.
module vga_timing
  import vga_pkg::*;
#(
  parameter int width  = H_VISIBLE,
  parameter int height = V_VISIBLE,
  parameter int hFront = H_FRONT,
  parameter int hSync  = H_SYNC,
  parameter int hBack  = H_BACK,
  parameter int vFront = V_FRONT,
  parameter int vSync  = V_SYNC,
  parameter int vBack  = V_BACK
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] hor_o,
  output logic [CNT_W-1:0] ver_o,
  output vga_ctl_t         ctl_o
);
  localparam int HMAX = width + hFront + hSync + hBack;
  localparam int VMAX = height + vFront + vSync + vBack;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HMAX - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VMAX - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(width);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(height);
  localparam logic [CNT_W-1:0] H_EDGE   = CNT_W'(width - 1);
  localparam logic [CNT_W-1:0] V_EDGE   = CNT_W'(height - 1);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(width + hFront);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(width + hFront + hSync - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(height + vFront);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(height + vFront + vSync - 1);

  logic [CNT_W-1:0] hor_q, hor_d, ver_q, ver_d;

  // Next raster position: ver steps only on the hor wrap, both wrap together at the last pixel.
  always_comb begin
    hor_d = hor_q + CNT_W'(1);
    ver_d = ver_q;
    if (hor_q == H_LAST) begin
      hor_d = '0;
      ver_d = (ver_q == V_LAST) ? '0 : ver_q + CNT_W'(1);
    end
  end

  // Counter registers, restart at (0,0) on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hor_q <= '0;
      ver_q <= '0;
    end else begin
      hor_q <= hor_d;
      ver_q <= ver_d;
    end
  end

  // Stage-0 decode of the current position.
  always_comb begin
    ctl_o.hs     = !((hor_q >= HS_START) && (hor_q <= HS_END));
    ctl_o.vs     = !((ver_q >= VS_START) && (ver_q <= VS_END));
    ctl_o.de     = (hor_q < H_VIS) && (ver_q < V_VIS);
    ctl_o.fs     = (hor_q == '0) && (ver_q == '0);
    ctl_o.border = (hor_q == '0) || (hor_q == H_EDGE) || (ver_q == '0) || (ver_q == V_EDGE);
  end

  assign hor_o = hor_q;
  assign ver_o = ver_q;
endmodule

// File: rtl/vga_reader.sv
// Frame-buffer reader: address generation, overlay latch, 2-stage control delay, output mux.
module vga_reader
  import vga_pkg::*;
#(
  parameter int width  = H_VISIBLE,
  parameter int height = V_VISIBLE,
  parameter int hFront = H_FRONT,
  parameter int hSync  = H_SYNC,
  parameter int hBack  = H_BACK,
  parameter int vFront = V_FRONT,
  parameter int vSync  = V_SYNC,
  parameter int vBack  = V_BACK
) (
  input  logic              clk24,
  input  logic              rst,
  output logic [ADDR_W-1:0] addr_mem1,
  input  logic [3:0]        din,
  input  logic              pattern_en,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              de,
  output logic              frame_start
);
  logic [CNT_W-1:0]  hor, ver;
  vga_ctl_t          ctl0;
  vga_ctl_t          ctl1_q, ctl2_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pattern_q;
  logic [3:0]        pix;

  vga_timing #(
    .width(width), .height(height),
    .hFront(hFront), .hSync(hSync), .hBack(hBack),
    .vFront(vFront), .vSync(vSync), .vBack(vBack)
  ) u_timing (
    .clk_i(clk24),
    .rst_i(rst),
    .hor_o(hor),
    .ver_o(ver),
    .ctl_o(ctl0)
  );

  // Linear frame-buffer address for visible pixels, parked at 0 in blanking.
  always_comb begin
    addr_d = '0;
    if (ctl0.de) addr_d = ADDR_W'(hor) + ADDR_W'(ver) * ADDR_W'(width);
  end

  // Stage 1 (address/ctl) and stage 2 (ctl, aligned with din); overlay request latched once per frame.
  always_ff @(posedge clk24) begin
    if (rst) begin
      addr_q    <= '0;
      ctl1_q    <= CTL_IDLE;
      ctl2_q    <= CTL_IDLE;
      pattern_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      ctl1_q <= ctl0;
      ctl2_q <= ctl1_q;
      if (ctl0.fs) pattern_q <= pattern_en;
    end
  end

  // din is already the registered memory output, so the colour mux sits on stage-2 registers.
  always_comb begin
    pix = (pattern_q && ctl2_q.border) ? 4'hF : din;
    if (!ctl2_q.de) pix = 4'h0;
  end

  assign addr_mem1   = addr_q;
  assign vga_r       = pix;
  assign vga_g       = pix;
  assign vga_b       = pix;
  assign vga_hs      = ctl2_q.hs;
  assign vga_vs      = ctl2_q.vs;
  assign de          = ctl2_q.de;
  assign frame_start = ctl2_q.fs;
endmodule

// File: tb/tb_vga_reader.sv
// Bench for vga_reader on a shrunken raster so several frames fit in a short run.
module tb_vga_reader;
  localparam int W  = 20, H = 10;
  localparam int HF = 4, HS = 6, HB = 5;
  localparam int VF = 2, VS = 3, VB = 4;
  localparam int HT = W + HF + HS + HB;   // 35
  localparam int VT = H + VF + VS + VB;   // 19
  localparam int FR = HT * VT;            // 665

  logic        clk24 = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] addr_mem1;
  logic [3:0]  din;
  logic        pattern_en = 1'b0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, de, frame_start;

  logic [3:0]  mem [W*H];

  int checks = 0, fails = 0;
  int k = 0;                 // raster position the counters hold since the last reset
  bit pat [int];             // overlay request seen at the start of each frame index
  int cnt_de, cnt_hs, cnt_vs, since_fs;
  bit seen_fs = 1'b0;

  vga_reader #(
    .width(W), .height(H), .hFront(HF), .hSync(HS), .hBack(HB),
    .vFront(VF), .vSync(VS), .vBack(VB)
  ) dut (
    .clk24(clk24), .rst(rst), .addr_mem1(addr_mem1), .din(din),
    .pattern_en(pattern_en), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .de(de), .frame_start(frame_start)
  );

  always #5 clk24 = ~clk24;

  // Synchronous-read frame buffer.
  always @(posedge clk24) din <= mem[int'(addr_mem1) % (W*H)];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int addr_of(input int p);
    int pp, h, v;
    pp = p % FR; h = pp % HT; v = pp / HT;
    return (h < W && v < H) ? h + v * W : 0;
  endfunction

  task automatic check_outputs();
    int q, pp, h, v, e_r;
    bit e_de, e_hs, e_vs, e_fs;
    chk("addr", addr_mem1, (k >= 1) ? addr_of(k - 1) : 0);
    e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_r = 0;
    if (k >= 2) begin
      q = k - 2; pp = q % FR; h = pp % HT; v = pp / HT;
      e_de = (h < W) && (v < H);
      e_hs = !(h >= W + HF && h < W + HF + HS);
      e_vs = !(v >= H + VF && v < H + VF + VS);
      e_fs = (pp == 0);
      if (e_de) begin
        if (pat[q / FR] && (h == 0 || h == W - 1 || v == 0 || v == H - 1)) e_r = 15;
        else e_r = int'(mem[h + v * W]);
      end
    end
    chk("de", de, e_de);
    chk("hs", vga_hs, e_hs);
    chk("vs", vga_vs, e_vs);
    chk("frame_start", frame_start, e_fs);
    chk("r", vga_r, e_r);
    chk("g", vga_g, e_r);
    chk("b", vga_b, e_r);
    // Whole-frame totals between consecutive frame_start pulses.
    if (k < 2) begin
      seen_fs = 0;
    end else begin
      if (frame_start === 1'b1) begin
        if (seen_fs) begin
          chk("fs_period", since_fs, FR);
          chk("de_per_frame", cnt_de, W * H);
          chk("hs_low_per_frame", cnt_hs, HS * VT);
          chk("vs_low_per_frame", cnt_vs, VS * HT);
        end
        seen_fs = 1; since_fs = 0; cnt_de = 0; cnt_hs = 0; cnt_vs = 0;
      end
      since_fs++;
      cnt_de += (de === 1'b1) ? 1 : 0;
      cnt_hs += (vga_hs === 1'b0) ? 1 : 0;
      cnt_vs += (vga_vs === 1'b0) ? 1 : 0;
    end
  endtask

  task automatic tick();
    @(posedge clk24);
    if (rst) k = 0;
    else begin
      if (k % FR == 0) pat[k / FR] = pattern_en;
      k++;
    end
    @(negedge clk24);
    check_outputs();
  endtask

  task automatic run_until(input int pos);
    int n = 0;
    while ((k % FR) != pos && n < 2 * FR) begin tick(); n++; end
    chk("reach_position", k % FR, pos);
  endtask

  initial begin
    int n;
    for (int i = 0; i < W * H; i++) mem[i] = 4'(i);

    // Reset hold, then first visible pixel latency.
    rst = 1'b1;
    repeat (5) tick();
    chk("rst_hs", vga_hs, 1);
    chk("rst_vs", vga_vs, 1);
    chk("rst_addr", addr_mem1, 0);
    rst = 1'b0;
    n = 0;
    while (de !== 1'b1 && n < 10) begin tick(); n++; end
    chk("first_de_latency", n, 2);
    chk("first_frame_start", frame_start, 1);

    // Two plain frames with addr[3:0] data.
    repeat (2 * FR) tick();

    // Overlay requested before frame N, withdrawn mid-frame N; frame N+1 clean.
    run_until(FR - 10);
    pattern_en = 1'b1;
    run_until(FR / 2);
    pattern_en = 1'b0;
    repeat (FR + FR / 2 + 5) tick();

    // Random frame-buffer contents, loaded while held in reset.
    rst = 1'b1;
    for (int i = 0; i < W * H; i++) mem[i] = 4'($urandom_range(0, 15));
    repeat (3) tick();
    rst = 1'b0;
    for (int c = 0; c < 3 * FR; c++) begin
      if ($urandom_range(0, 99) < 2) pattern_en = ~pattern_en;
      tick();
    end

    // One-cycle reset in the middle of a frame, at (7,5).
    run_until(5 * HT + 7);
    rst = 1'b1;
    tick();
    chk("midrst_de", de, 0);
    chk("midrst_addr", addr_mem1, 0);
    rst = 1'b0;
    tick();
    tick();
    chk("midrst_fs", frame_start, 1);
    repeat (FR + 10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
